uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among four byte requesters.
// Each grant registers the selected byte and emits a single-cycle start strobe.
// The block then stays busy for one full frame slot before it arbitrates again.
module uart_tx_arbiter #(
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned CLK_FRE    = 50_000_000,
  parameter int unsigned GUARD_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data,
  output logic        tx_data_flag,
  output logic        busy,
  output logic [1:0]  grant_id
);

  // Start bit, 8 data bits, stop bit, then the guard idle time.
  localparam int unsigned FrameCycles = (CLK_FRE / BAUD) * (10 + GUARD_BITS);
  localparam int unsigned CntW        = $clog2(FrameCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(FrameCycles - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      sel;
  logic [1:0]      idx;
  logic            found;

  // Round-robin pick: scan upward from the requester after the last grant.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = grant_id + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Two-state slot FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tx_data      <= 8'h00;
      tx_data_flag <= 1'b0;
      ack          <= 4'b0000;
      busy         <= 1'b0;
      grant_id     <= 2'd3;
    end else begin
      // Strobe and ack are pulses; they default low every cycle.
      ack          <= 4'b0000;
      tx_data_flag <= 1'b0;
      case (state_q)
        StIdle: begin
          if (en && found) begin
            tx_data      <= req_data[{sel, 3'b000} +: 8];
            tx_data_flag <= 1'b1;
            ack          <= 4'b0001 << sel;
            grant_id     <= sel;
            cnt_q        <= CntLoad;
            busy         <= 1'b1;
            state_q      <= StSend;
          end
        end
        StSend: begin
          // en is deliberately ignored here so a started frame always completes.
          if (cnt_q == '0) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
